// File: rtl/router_pkg.sv
// router_pkg: shared header field positions, port count, FSM encoding and output buffer entry type
package router_pkg;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;
  localparam int NUM_PORTS = 3;
  typedef enum logic [1:0] {IDLE, HDR_RD, HDR_WAIT, BODY_RD} state_e;
  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] port;
  } obuf_t;
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'(NUM_PORTS - 1)) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/router_obuf.sv
// router_obuf: synchronous FIFO of tagged output bytes (data, last, port)
//   clk/rst          clock, synchronous active-high reset
//   wr_en_i/wr_data_i push side; rd_en_i pops the head shown on rd_data_o
//   count_o/empty_o/full_o occupancy status; rd_data_o reads zero when empty
module router_obuf import router_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  obuf_t                      wr_data_i,
  input  logic                       rd_en_i,
  output obuf_t                      rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  obuf_t mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic wr, rd;
  assign empty_o = count_q == '0;
  assign full_o = count_q == CW'(DEPTH);
  assign wr = wr_en_i && !full_o;
  assign rd = rd_en_i && !empty_o;
  assign count_o = count_q;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  always_ff @(posedge clk) if (wr) mem_q[wr_ptr_q] <= wr_data_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (wr) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (rd) rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/router_out_arbiter.sv
// router_out_arbiter: packet-granular round-robin drain of three router FIFOs into one ready/valid byte stream
//   clock/reset                  single clock, synchronous active-high reset
//   vld_out_k/data_out_k/read_enb_k  router FIFO side (data valid one cycle after read_enb)
//   m_data/m_valid/m_ready/m_last/m_port  downstream stream, m_last on the parity byte
//   busy   a packet is granted; abort  one-cycle pulse on stall timeout
module router_out_arbiter import router_pkg::*; #(
  parameter int OBUF_DEPTH = 4,
  parameter int STALL_LIMIT = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic [1:0] m_port,
  output logic       busy,
  output logic       abort
);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  state_e state_q, state_d;
  logic [1:0] gnt_q, gnt_d, rr_q, rr_d, ifl_port_q, p1, p2;
  logic [6:0] rem_q, rem_d;
  logic [SW-1:0] stall_q, stall_d;
  logic abort_q, abort_d, ifl_q, ifl_last_q;
  logic [NUM_PORTS-1:0] vld;
  logic vld_g, credit, rd, active, timeout, empty, full;
  logic [7:0] din_ret;
  logic [$clog2(OBUF_DEPTH+1)-1:0] count;
  obuf_t wr_entry, head;
  assign vld = {vld_out_2, vld_out_1, vld_out_0};
  assign vld_g = (gnt_q == 2'd0) ? vld_out_0 : (gnt_q == 2'd1) ? vld_out_1 : vld_out_2;
  assign din_ret = (ifl_port_q == 2'd0) ? data_out_0 : (ifl_port_q == 2'd1) ? data_out_1 : data_out_2;
  // the in-flight read already owns a buffer slot, so it counts against credit
  assign credit = (int'(count) + int'(ifl_q)) < OBUF_DEPTH;
  assign active = state_q == HDR_RD || state_q == BODY_RD;
  assign timeout = active && !vld_g && stall_q == SW'(STALL_LIMIT - 1);
  assign p1 = rr_next(rr_q);
  assign p2 = rr_next(p1);
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rr_q <= 2'd2;
      rem_q <= '0;
      stall_q <= '0;
      abort_q <= 1'b0;
      ifl_q <= 1'b0;
      ifl_last_q <= 1'b0;
      ifl_port_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rr_q <= rr_d;
      rem_q <= rem_d;
      stall_q <= stall_d;
      abort_q <= abort_d;
      ifl_q <= rd;
      ifl_last_q <= rd && state_q == BODY_RD && rem_q == 7'd1;
      ifl_port_q <= gnt_q;
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    rr_d = rr_q;
    rem_d = rem_q;
    stall_d = '0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: if (|vld) begin
        gnt_d = vld[p1] ? p1 : vld[p2] ? p2 : rr_q;
        state_d = HDR_RD;
      end
      HDR_RD: begin
        stall_d = vld_g ? '0 : stall_q + SW'(1);
        if (timeout) begin
          abort_d = 1'b1;
          rr_d = gnt_q;
          state_d = IDLE;
        end else if (rd) state_d = HDR_WAIT;
      end
      HDR_WAIT: begin
        rem_d = {1'b0, din_ret[LEN_MSB:LEN_LSB]} + 7'd1;
        state_d = BODY_RD;
      end
      BODY_RD: begin
        stall_d = vld_g ? '0 : stall_q + SW'(1);
        if (timeout) begin
          abort_d = 1'b1;
          rr_d = gnt_q;
          state_d = IDLE;
        end else if (rd) begin
          rem_d = rem_q - 7'd1;
          if (rem_q == 7'd1) begin
            rr_d = gnt_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rd = active && vld_g && credit;
    read_enb_0 = rd && gnt_q == 2'd0;
    read_enb_1 = rd && gnt_q == 2'd1;
    read_enb_2 = rd && gnt_q == 2'd2;
    busy = state_q != IDLE;
    abort = abort_q;
    m_valid = !empty;
    m_data = head.data;
    m_last = head.last;
    m_port = head.port;
  end
  assign wr_entry = '{data: din_ret, last: ifl_last_q, port: ifl_port_q};
  router_obuf #(.DEPTH(OBUF_DEPTH)) u_obuf (
    .clk      (clock),
    .rst      (reset),
    .wr_en_i  (ifl_q),
    .wr_data_i(wr_entry),
    .rd_en_i  (m_ready),
    .rd_data_o(head),
    .count_o  (count),
    .empty_o  (empty),
    .full_o   (full)
  );
  logic unused_full;
  assign unused_full = full;
endmodule

// File: tb/tb_router_out_arbiter.sv
// tb_router_out_arbiter: directed scenario bench with a router FIFO model and stream monitor
module tb_router_out_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 32;
  logic clock = 1'b0, reset = 1'b1;
  logic vld_out_0 = 1'b0, vld_out_1 = 1'b0, vld_out_2 = 1'b0;
  logic [7:0] data_out_0 = '0, data_out_1 = '0, data_out_2 = '0;
  logic read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] m_data;
  logic m_valid, m_last, busy, abort;
  logic m_ready = 1'b0;
  logic [1:0] m_port;
  logic [7:0] q0[$], q1[$], q2[$];
  logic [10:0] cap[$];
  logic [10:0] held;
  logic hold_q = 1'b0;
  int rd_cnt0 = 0, rd_cnt1 = 0, rd_cnt2 = 0, abort_cnt = 0;
  int multi_err = 0, ovf_err = 0, stab_err = 0, outstanding = 0;
  int n_checks = 0, n_fail = 0;

  always #5 clock = ~clock;

  router_out_arbiter #(.OBUF_DEPTH(DEPTH), .STALL_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_port(m_port), .busy(busy), .abort(abort)
  );

  always @(negedge clock) begin
    vld_out_0 <= q0.size() != 0;
    vld_out_1 <= q1.size() != 0;
    vld_out_2 <= q2.size() != 0;
  end

  always @(posedge clock) begin
    if (read_enb_0 && q0.size() != 0) data_out_0 <= q0.pop_front();
    if (read_enb_1 && q1.size() != 0) data_out_1 <= q1.pop_front();
    if (read_enb_2 && q2.size() != 0) data_out_2 <= q2.pop_front();
    rd_cnt0 += int'(read_enb_0);
    rd_cnt1 += int'(read_enb_1);
    rd_cnt2 += int'(read_enb_2);
    if (int'(read_enb_0) + int'(read_enb_1) + int'(read_enb_2) > 1) multi_err++;
    if (abort) abort_cnt++;
    if (m_valid && m_ready) cap.push_back({m_port, m_last, m_data});
    if (hold_q && {m_port, m_last, m_data} !== held) stab_err++;
    hold_q = !reset && m_valid && !m_ready;
    held = {m_port, m_last, m_data};
    outstanding = reset ? 0 : outstanding + int'(read_enb_0 | read_enb_1 | read_enb_2) - int'(m_valid && m_ready);
    if (outstanding > DEPTH) ovf_err++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input int p, input logic [7:0] b);
    if (p == 0) q0.push_back(b);
    else if (p == 1) q1.push_back(b);
    else q2.push_back(b);
  endtask

  function automatic logic [10:0] ent(input int p, input logic l, input logic [7:0] d);
    return {2'(p), l, d};
  endfunction

  task automatic wait_cap(input int n, input int budget, input string tag);
    int k = 0;
    while (cap.size() < n && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (cap.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: captured %0d bytes, required %0d", tag, cap.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_ready = 1'b0;
    tick(2);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    n_checks++; if (m_port !== 2'd0) begin n_fail++; $display("FAIL reset_m_port: got %0d want 0", m_port); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b want 0", abort); end
    n_checks++; if ({read_enb_2, read_enb_1, read_enb_0} !== 3'b000) begin n_fail++; $display("FAIL reset_read_enb: got %b want 000", {read_enb_2, read_enb_1, read_enb_0}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] pkt [5] = '{8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'h55};
    int base = rd_cnt1;
    int lat = 0;
    int k = 0;
    m_ready = 1'b1;
    cap.delete();
    for (int i = 0; i < 5; i++) push(1, pkt[i]);
    while (!m_valid && lat < 10) begin
      tick();
      lat++;
    end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL single_latency: m_valid after %0d cycles, want 3", lat); end
    while (rd_cnt1 - base < 5 && k < 30) begin
      tick();
      k++;
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after_last_read: got %b want 0", busy); end
    wait_cap(5, 20, "single");
    tick(3);
    n_checks++; if (rd_cnt1 - base != 5) begin n_fail++; $display("FAIL single_read_count: got %0d want 5", rd_cnt1 - base); end
    n_checks++; if (cap.size() != 5) begin n_fail++; $display("FAIL single_byte_count: got %0d want 5", cap.size()); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (cap[i] !== ent(1, i == 4, pkt[i])) begin
        n_fail++;
        $display("FAIL single_byte%0d: got port=%0d last=%b data=%h want port=1 last=%b data=%h", i, cap[i][10:9], cap[i][8], cap[i][7:0], i == 4, pkt[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [10:0] exp [12];
    reset = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    for (int p = 0; p < 3; p++) begin
      push(p, 8'(p));
      push(p, 8'hA0 + 8'(p));
    end
    tick(2);
    cap.delete();
    reset = 1'b0;
    m_ready = 1'b1;
    wait_cap(6, 60, "rr_first");
    for (int p = 0; p < 3; p++) begin
      push(p, 8'(p));
      push(p, 8'hC0 + 8'(p));
    end
    wait_cap(12, 80, "rr_refill");
    for (int p = 0; p < 3; p++) begin
      exp[2*p] = ent(p, 1'b0, 8'(p));
      exp[2*p+1] = ent(p, 1'b1, 8'hA0 + 8'(p));
      exp[6+2*p] = ent(p, 1'b0, 8'(p));
      exp[7+2*p] = ent(p, 1'b1, 8'hC0 + 8'(p));
    end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (cap[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL rr_byte%0d: got port=%0d last=%b data=%h want port=%0d last=%b data=%h", i, cap[i][10:9], cap[i][8], cap[i][7:0], exp[i][10:9], exp[i][8], exp[i][7:0]);
      end
    end
    n_checks++; if (multi_err != 0) begin n_fail++; $display("FAIL rr_single_read_strobe: %0d cycles with several read_enb, want 0", multi_err); end
  endtask

  task automatic test_back_pressure();
    logic [7:0] pkt [12];
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0;
    pkt[0] = 8'h2A;
    for (int i = 1; i <= 10; i++) pkt[i] = 8'h0F + 8'(i);
    pkt[11] = 8'h5A;
    cap.delete();
    for (int i = 0; i < 12; i++) push(2, pkt[i]);
    while (cap.size() < 12 && k < 300) begin
      m_ready = pat[k % 4];
      tick();
      k++;
    end
    m_ready = 1'b1;
    n_checks++; if (cap.size() != 12) begin n_fail++; $display("FAIL bp_byte_count: got %0d want 12", cap.size()); end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (cap[i] !== ent(2, i == 11, pkt[i])) begin
        n_fail++;
        $display("FAIL bp_byte%0d: got port=%0d last=%b data=%h want port=2 last=%b data=%h", i, cap[i][10:9], cap[i][8], cap[i][7:0], i == 11, pkt[i]);
      end
    end
    n_checks++; if (ovf_err != 0) begin n_fail++; $display("FAIL bp_outstanding: %0d cycles above %0d bytes, want 0", ovf_err, DEPTH); end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_hold_stable: %0d unstable stalled cycles, want 0", stab_err); end
  endtask

  task automatic test_stall_abort();
    logic [10:0] exp [5];
    int ab0 = abort_cnt;
    int k = 0;
    exp = '{ent(0, 1'b0, 8'h14), ent(0, 1'b0, 8'h31), ent(0, 1'b0, 8'h32), ent(1, 1'b0, 8'h01), ent(1, 1'b1, 8'h77)};
    m_ready = 1'b1;
    cap.delete();
    push(0, 8'h14); push(0, 8'h31); push(0, 8'h32);
    push(1, 8'h01); push(1, 8'h77);
    while (abort_cnt == ab0 && k < 100) begin
      tick();
      k++;
    end
    wait_cap(5, 40, "stall");
    tick(5);
    n_checks++; if (abort_cnt - ab0 != 1) begin n_fail++; $display("FAIL stall_abort_pulses: got %0d want 1", abort_cnt - ab0); end
    n_checks++; if (cap.size() != 5) begin n_fail++; $display("FAIL stall_byte_count: got %0d want 5", cap.size()); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (cap[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL stall_byte%0d: got port=%0d last=%b data=%h want port=%0d last=%b data=%h", i, cap[i][10:9], cap[i][8], cap[i][7:0], exp[i][10:9], exp[i][8], exp[i][7:0]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [10:0] exp [4];
    exp = '{ent(0, 1'b0, 8'h00), ent(0, 1'b1, 8'hE0), ent(2, 1'b0, 8'h02), ent(2, 1'b1, 8'hE2)};
    m_ready = 1'b0;
    cap.delete();
    push(0, 8'h28);
    for (int i = 0; i < 11; i++) push(0, 8'h60 + 8'(i));
    tick(5);
    n_checks++; if (busy !== 1'b1 || m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_precondition: busy=%b m_valid=%b want 1 1", busy, m_valid); end
    reset = 1'b1;
    tick();
    q0.delete(); q1.delete(); q2.delete();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_m_valid: got %b want 0", m_valid); end
    n_checks++; if ({read_enb_2, read_enb_1, read_enb_0} !== 3'b000) begin n_fail++; $display("FAIL mid_read_enb: got %b want 000", {read_enb_2, read_enb_1, read_enb_0}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    reset = 1'b0;
    cap.delete();
    m_ready = 1'b1;
    push(2, 8'h02); push(2, 8'hE2);
    push(0, 8'h00); push(0, 8'hE0);
    wait_cap(4, 40, "mid");
    tick(3);
    n_checks++; if (cap.size() != 4) begin n_fail++; $display("FAIL mid_byte_count: got %0d want 4", cap.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (cap[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL mid_byte%0d: got port=%0d last=%b data=%h want port=%0d last=%b data=%h", i, cap[i][10:9], cap[i][8], cap[i][7:0], exp[i][10:9], exp[i][8], exp[i][7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_stall_abort();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Packet-granular round-robin arbiter that drains the three router output FIFOs into one downstream byte stream. It sits after the 1x3 router, on the read side. It watches vld_out_0..2, drives read_enb_0..2, and forwards whole packets (header, payload, parity) without interleaving. A small output buffer with a ready/valid handshake decouples the router's one-cycle FIFO read latency from downstream back-pressure.

## Interface
- OBUF_DEPTH, default 4: output buffer entries; legal values are 3 to 16.
- STALL_LIMIT, default 32: consecutive idle cycles on the granted port mid-packet before the packet is aborted.
- clock  in  1  the single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- vld_out_0, vld_out_1, vld_out_2  in  1 each  the router FIFO is non-empty.
- data_out_0, data_out_1, data_out_2  in  8 each  router FIFO read data; valid one cycle after the matching read_enb.
- read_enb_0, read_enb_1, read_enb_2  out  1 each  router FIFO read strobe; at most one is high per cycle.
- m_data  out  8  downstream byte.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts the byte; a transfer happens when m_valid and m_ready are both high.
- m_last  out  1  marks the parity byte, which is the last byte of the packet.
- m_port  out  2  source port of the current byte (0 to 2).
- busy  out  1  a packet is granted (state is not IDLE).
- abort  out  1  one-cycle pulse when a packet is abandoned on stall timeout.

## Operation
- Packet format:
  - header byte: bits [7:2] = payload length L (0 to 63), bits [1:0] = address;
  - then L payload bytes;
  - then 1 parity byte.
  - Total length is L+2 bytes.
- State machine:
  - **IDLE:** if any vld_out is high, grant the first requesting port in round-robin order starting at rr_ptr+1 (mod 3), then go to HDR_RD. After reset rr_ptr = 2, so port 0 has first priority.
  - **HDR_RD:** issue a single read on the granted port when its vld_out is high and there is buffer credit, then go to HDR_WAIT.
  - **HDR_WAIT:** the header byte returns this cycle. Load remaining = L+1 and go to BODY_RD.
  - **BODY_RD:** issue a read whenever the granted vld_out is high and there is credit, and decrement remaining on each read. On the read that takes remaining to 0, set rr_ptr to the granted port and go to IDLE.
- Credit rule: a read may be issued only when (buffer occupancy + reads in flight) < OBUF_DEPTH. Reads in flight is 0 or 1.
- Every returning byte is written to the output buffer with its m_port and m_last tags. m_last is set only on the parity byte (the byte returned when remaining reaches 0).
- Reads stay on the granted port even if other ports request.
- Stall timeout:
  - In HDR_RD or BODY_RD, a counter increments on every cycle the granted vld_out is low and clears on every cycle it is high.
  - When the counter reaches STALL_LIMIT: pulse abort, set rr_ptr to the granted port, and go to IDLE.
  - Bytes already in the buffer still drain. No m_last is emitted for the aborted packet.
  - This covers the router's soft-reset flush of an unserviced FIFO.
- The output buffer is FIFO-ordered. m_valid = buffer not empty. m_data, m_last and m_port come from the buffer head.
- Reset mid-packet: the state machine goes to IDLE, the buffer is emptied, and an in-flight returning byte is discarded.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 2;
  - read_enb_0..2 = 0;
  - m_valid = 0, m_data = 0, m_last = 0, m_port = 0;
  - busy = 0, abort = 0.
- read_enb is a combinational decode of state, granted port, vld_out and credit. It is never high in IDLE or HDR_WAIT.
- Latency:
  - the first vld_out rising in IDLE gives read_enb in cycle +1;
  - that header reaches m_valid at cycle +3 (one cycle of router read latency plus one buffer write cycle).
- Throughput: one byte per cycle in BODY_RD when m_ready is held high and the source stays non-empty. The header costs one bubble cycle (HDR_WAIT).
- Back-pressure: while m_valid is high and m_ready is low, m_data, m_last and m_port stay stable. Reads stop once credit is exhausted, and no byte is ever dropped.
- Simultaneous buffer write and read in one cycle: occupancy is unchanged.
- A new grant can be issued in the cycle after the final body read. Packets from different ports are never interleaved in the output.

## Structure
- Shared package router_pkg contains:
  - the header field positions (LEN_MSB = 7, LEN_LSB = 2, ADDR_MSB = 1, ADDR_LSB = 0);
  - NUM_PORTS = 3;
  - the state encoding (IDLE, HDR_RD, HDR_WAIT, BODY_RD).
- Sub-module router_obuf: a synchronous FIFO OBUF_DEPTH entries deep and 11 bits wide (data, last, port). It exposes count, empty and full.
- Top level contains the state machine, round-robin pointer, remaining counter, stall counter, read decode and credit logic.

## Test plan
- **Single packet:** after reset, port 1 holds header 0x0D (L=3), payload AA BB CC, parity 0x55, and m_ready is held high. Required: read_enb_1 pulses 5 times, m_data = 0D AA BB CC 55, m_port = 1, m_last high only on 0x55, busy falls after the last read.
- **Round-robin:** all three ports hold 2-byte packets (L=0) at reset. Required: grant order is 0, 1, 2, then 0 on refill, with no interleaving in the m_port sequence.
- **Back-pressure:** an L=10 packet on port 2 with m_ready toggling 1,0,0,1. Required: no more than OBUF_DEPTH bytes outstanding, m_data held stable while m_valid=1 and m_ready=0, all 12 bytes delivered in order.
- **Stall abort:** after the header and 2 payload bytes (L=5), vld_out_0 stays low for 32 cycles. Required: abort pulses one cycle, the 3 buffered bytes still drain, no m_last is emitted, and the next grant is port 1 if it is requesting.
- **Reset mid-packet:** reset is asserted during BODY_RD with 2 bytes buffered. Required: next cycle m_valid = 0, read_enb all 0, busy = 0, and a fresh packet afterwards starts from port 0 priority.
